// File: rtl/gmii_phy_speed_ctrl.sv
// gmii_phy_speed_ctrl
// Clause 22 MDIO master that periodically reads a PHY status register,
// decodes link state and negotiated speed, and drives mii_select
// (1 = 10/100 via the PHY MII TX clock, 0 = 1000 via the local clk).
// Optional build macro: GMII_PHY_SPEED_CTRL_TA_CHECK_EN
//   When defined, the second turnaround bit is checked; a 1 there means no
//   PHY answered, so the frame is not decoded and err pulses instead of
//   status_valid. When undefined, err is tied low and every frame decodes.
module gmii_phy_speed_ctrl #(
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter logic [4:0]  STATUS_REG    = 5'd17,
    parameter int unsigned LINK_BIT      = 10,
    parameter int unsigned SPEED_MSB     = 15,
    parameter int unsigned MDC_DIV       = 4,
    parameter int unsigned POLL_INTERVAL = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_req,
    input  logic       mdio_i,
    output logic       mdc_o,
    output logic       mdio_o,
    output logic       mdio_t,
    output logic       busy,
    output logic       status_valid,
    output logic       link_up,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       err
);

    localparam int unsigned PW = $clog2(2 * MDC_DIV);
    localparam int unsigned TW = (POLL_INTERVAL < 2) ? 1 : $clog2(POLL_INTERVAL + 1);

    // ST=01, OP=10 (read), PHY address, register address; padded to 16 bits
    localparam logic [15:0] HDR_PAD = {2'b11, 2'b01, 2'b10, PHY_ADDR, STATUS_REG};

    // Frame bit index at which read-data bit i is sampled (DATA starts at bit 48, MSB first)
    localparam logic [6:0] LINK_POS   = 7'(63 - LINK_BIT);
    localparam logic [6:0] SPD_HI_POS = 7'(63 - SPEED_MSB);
    localparam logic [6:0] SPD_LO_POS = 7'(64 - SPEED_MSB);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_phase;
    logic [6:0]      r_bit;
    logic [TW-1:0]   r_timer;
    logic            r_pending;
    logic            r_cap_link;
    logic [1:0]      r_cap_spd;
    logic            r_mdc;
    logic            r_mdio_o;
    logic            r_mdio_t;
    logic            r_busy;
    logic            r_status_valid;
    logic            r_link_up;
    logic [1:0]      r_speed;
    logic            r_mii_select;

    logic            w_sample;
    logic            w_bit_end;
    logic [6:0]      w_next_bit;
    logic [3:0]      w_hdr_idx;
    state_t          w_next_state;
    logic            w_next_mdio;
    logic            w_next_release;
    logic            w_expired;
    logic            w_start;
    logic            w_decode_en;

`ifdef GMII_PHY_SPEED_CTRL_TA_CHECK_EN
    logic            r_ta_fail;
    logic            r_err;
    assign w_decode_en = !r_ta_fail;
    assign err         = r_err;
`else
    assign w_decode_en = 1'b1;
    assign err         = 1'b0;
`endif

    assign w_sample   = (r_phase == PW'(MDC_DIV));
    assign w_bit_end  = (r_phase == PW'(2 * MDC_DIV - 1));
    assign w_next_bit = r_bit + 7'd1;
    // Header bits occupy frame bits 32..45, whose low nibble is the header offset
    assign w_hdr_idx  = 4'd13 - w_next_bit[3:0];
    assign w_expired  = (r_timer <= TW'(1));

    // A frame starts from IDLE on timer/request, or straight out of DONE on a request
    assign w_start = ((r_state == ST_IDLE) && (r_pending || poll_req || w_expired)) ||
                     ((r_state == ST_DONE) && (r_pending || poll_req));

    // Next-bit phase decode: which section the upcoming bit belongs to and what to drive
    always_comb begin
        w_next_state   = ST_DONE;
        w_next_mdio    = 1'b1;
        w_next_release = 1'b1;
        if (w_next_bit < 7'd32) begin
            w_next_state   = ST_PRE;
            w_next_release = 1'b0;
        end else if (w_next_bit < 7'd46) begin
            w_next_state   = ST_HDR;
            w_next_release = 1'b0;
            w_next_mdio    = HDR_PAD[w_hdr_idx];
        end else if (w_next_bit < 7'd48) begin
            w_next_state   = ST_TA;
        end else if (w_next_bit < 7'd64) begin
            w_next_state   = ST_DATA;
        end
    end

    // Frame sequencer, MDC generation, sampling, decode and poll timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_phase        <= '0;
            r_bit          <= '0;
            r_timer        <= '0;
            r_pending      <= 1'b0;
            r_cap_link     <= 1'b0;
            r_cap_spd      <= '0;
            r_mdc          <= 1'b0;
            r_mdio_o       <= 1'b1;
            r_mdio_t       <= 1'b1;
            r_busy         <= 1'b0;
            r_status_valid <= 1'b0;
            r_link_up      <= 1'b0;
            r_speed        <= '0;
            r_mii_select   <= 1'b0;
`ifdef GMII_PHY_SPEED_CTRL_TA_CHECK_EN
            r_ta_fail      <= 1'b0;
            r_err          <= 1'b0;
`endif
        end else begin
            r_status_valid <= 1'b0;
`ifdef GMII_PHY_SPEED_CTRL_TA_CHECK_EN
            r_err          <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_mdc    <= 1'b0;
                    r_mdio_o <= 1'b1;
                    r_mdio_t <= 1'b1;
                    if (!w_start && (r_timer != '0))
                        r_timer <= r_timer - 1'b1;
                end
                ST_DONE: begin
                    r_mdc    <= 1'b0;
                    r_mdio_o <= 1'b1;
                    r_mdio_t <= 1'b1;
                    r_timer  <= TW'(POLL_INTERVAL);
                    if (w_decode_en) begin
                        r_link_up <= r_cap_link && (r_cap_spd != 2'b11);
                        if (r_cap_link && (r_cap_spd != 2'b11)) begin
                            r_speed      <= r_cap_spd;
                            r_mii_select <= (r_cap_spd != 2'b10);
                        end
                    end
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    if (poll_req)
                        r_pending <= 1'b1;
                    r_phase <= r_phase + 1'b1;
                    if (r_phase == PW'(MDC_DIV - 1))
                        r_mdc <= 1'b1;
                    // Only link and speed bits are kept; they are picked off at
                    // their serial positions as the word streams in MSB first.
                    if (w_sample) begin
                        if (r_bit == LINK_POS)
                            r_cap_link <= mdio_i;
                        if (r_bit == SPD_HI_POS)
                            r_cap_spd[1] <= mdio_i;
                        if (r_bit == SPD_LO_POS)
                            r_cap_spd[0] <= mdio_i;
`ifdef GMII_PHY_SPEED_CTRL_TA_CHECK_EN
                        if (r_bit == 7'd47)
                            r_ta_fail <= mdio_i;
`endif
                    end
                    if (w_bit_end) begin
                        r_phase  <= '0;
                        r_mdc    <= 1'b0;
                        r_bit    <= w_next_bit;
                        r_state  <= w_next_state;
                        r_mdio_o <= w_next_mdio;
                        r_mdio_t <= w_next_release;
                        if (w_next_state == ST_DONE) begin
                            r_status_valid <= w_decode_en;
`ifdef GMII_PHY_SPEED_CTRL_TA_CHECK_EN
                            r_err          <= r_ta_fail;
`endif
                        end
                    end
                end
            endcase
            // Frame start overrides the per-state updates above
            if (w_start) begin
                r_state   <= ST_PRE;
                r_phase   <= '0;
                r_bit     <= '0;
                r_pending <= 1'b0;
                r_mdc     <= 1'b0;
                r_mdio_o  <= 1'b1;
                r_mdio_t  <= 1'b0;
                r_busy    <= 1'b1;
`ifdef GMII_PHY_SPEED_CTRL_TA_CHECK_EN
                r_ta_fail <= 1'b0;
`endif
            end
        end
    end

    assign mdc_o        = r_mdc;
    assign mdio_o       = r_mdio_o;
    assign mdio_t       = r_mdio_t;
    assign busy         = r_busy;
    assign status_valid = r_status_valid;
    assign link_up      = r_link_up;
    assign speed        = r_speed;
    assign mii_select   = r_mii_select;

endmodule
